// File: rtl/id_keystroke_encoder_if.sv
// Request/keystroke bundle between a scripted-entry driver and the
// ID keystroke encoder.
interface id_keystroke_encoder_if #(
  parameter int NUM_DIGITS = 7
);
  logic                    start;
  logic [1:0]              mode;
  logic [4*NUM_DIGITS-1:0] id;
  logic [7:0]              key_code;
  logic                    key_on;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output start, mode, id,
    input  key_code, key_on, busy, done, err
  );

  modport slave (
    input  start, mode, id,
    output key_code, key_on, busy, done, err
  );
endinterface

// File: rtl/id_keystroke_encoder.sv
// Emits a parking ID, Escape or Ctrl+A as a timed PS/2 set-2
// key_code/key_on stream for the ID-entry decoder.
module id_keystroke_encoder #(
  parameter int NUM_DIGITS  = 7,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  id_keystroke_encoder_if.slave bus
);
  localparam int IDW = 4 * NUM_DIGITS;
  localparam int IW  = $clog2(NUM_DIGITS + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE, PRESS, RELEASE, FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d, idx_inc;
  logic             sub_q, sub_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       code_q, code_d;
  logic             on_q, on_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             req_ok;
  logic [7:0]       first_code;

  function automatic logic [7:0] digit_code(input logic [3:0] n);
    logic [7:0] c;
    c = 8'h00;
    case (n)
      4'd0: c = 8'h45;
      4'd1: c = 8'h16;
      4'd2: c = 8'h1E;
      4'd3: c = 8'h26;
      4'd4: c = 8'h25;
      4'd5: c = 8'h2E;
      4'd6: c = 8'h36;
      4'd7: c = 8'h3D;
      4'd8: c = 8'h3E;
      4'd9: c = 8'h46;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Digit 0 is the most significant nibble.
  function automatic logic [3:0] nib_at(
    input logic [IDW-1:0] v,
    input logic [IW-1:0]  i
  );
    logic [IDW-1:0] s;
    s = v << {i, 2'b00};
    return s[IDW-1 -: 4];
  endfunction

  function automatic logic all_dec(input logic [IDW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (v[4*k +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    req_ok     = 1'b0;
    first_code = 8'h00;
    case (bus.mode)
      2'd0: begin
        req_ok     = all_dec(bus.id);
        first_code = digit_code(bus.id[IDW-1 -: 4]);
      end
      2'd1: begin
        req_ok     = 1'b1;
        first_code = 8'h76;
      end
      2'd2: begin
        req_ok     = 1'b1;
        first_code = 8'h14;
      end
      default: req_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    id_d    = id_q;
    mode_d  = mode_q;
    code_d  = code_q;
    on_d    = on_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        id_d   = bus.id;
        mode_d = bus.mode;
        cnt_d  = '0;
        idx_d  = '0;
        sub_d  = 1'b0;
        if (req_ok) begin
          err_d   = 1'b0;
          busy_d  = 1'b1;
          on_d    = 1'b1;
          code_d  = first_code;
          state_d = PRESS;
        end else begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end
      PRESS: if (cnt_q == HOLD_LAST) begin
        cnt_d = '0;
        // Ctrl+A rolls straight from Ctrl to A without a release.
        if (mode_q == 2'd2 && !sub_q) begin
          sub_d  = 1'b1;
          code_d = 8'h1C;
        end else begin
          on_d    = 1'b0;
          state_d = RELEASE;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RELEASE: if (cnt_q == GAP_LAST) begin
        cnt_d = '0;
        if (mode_q != 2'd0 || idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          code_d  = 8'h00;
          state_d = FINISH;
        end else begin
          idx_d   = idx_inc;
          code_d  = digit_code(nib_at(id_q, idx_inc));
          on_d    = 1'b1;
          state_d = PRESS;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      id_q    <= '0;
      mode_q  <= 2'd0;
      code_q  <= 8'h00;
      on_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      id_q    <= id_d;
      mode_q  <= mode_d;
      code_q  <= code_d;
      on_q    <= on_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.key_code = code_q;
  assign bus.key_on   = on_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule
